// File: rtl/id_ex_decode.sv
// ID/EX pipeline register with MIPS R/I-type decode into ALU op, operands and destination.
// Also keeps a saturating count of illegal instructions accepted into the stage.
module id_ex_decode (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        stall,
    input  logic        flush,
    output logic        ex_valid,
    output logic [4:0]  ex_aluop,
    output logic [31:0] ex_a,
    output logic [31:0] ex_b,
    output logic        ex_regwrite,
    output logic [4:0]  ex_dst,
    output logic        ex_illegal,
    output logic [7:0]  illegal_cnt
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 5;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned CNT_W  = 8;

    localparam logic [OP_W-1:0] ALU_ADD  = 5'b00000;
    localparam logic [OP_W-1:0] ALU_SUB  = 5'b00001;
    localparam logic [OP_W-1:0] ALU_SLT  = 5'b00101;
    localparam logic [OP_W-1:0] ALU_SLTU = 5'b00111;
    localparam logic [OP_W-1:0] ALU_SLL  = 5'b01000;
    localparam logic [OP_W-1:0] ALU_SRL  = 5'b01001;
    localparam logic [OP_W-1:0] ALU_SRA  = 5'b01011;
    localparam logic [OP_W-1:0] ALU_AND  = 5'b11000;
    localparam logic [OP_W-1:0] ALU_OR   = 5'b11110;
    localparam logic [OP_W-1:0] ALU_XOR  = 5'b10110;
    localparam logic [OP_W-1:0] ALU_NOR  = 5'b10001;

    localparam logic [CNT_W-1:0] CNT_MAX = 8'hFF;

    logic [5:0]        w_op;
    logic [5:0]        w_fn;
    logic [DATA_W-1:0] w_sext;
    logic [DATA_W-1:0] w_zext;
    logic              w_legal;
    logic [OP_W-1:0]   w_aluop;
    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b;
    logic [REG_W-1:0]  w_dst;
    logic              w_regwrite;
    logic              w_unused_rs_field;

    logic              r_valid;
    logic [OP_W-1:0]   r_aluop;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic              r_regwrite;
    logic [REG_W-1:0]  r_dst;
    logic              r_illegal;
    logic [CNT_W-1:0]  r_cnt;

    // rs index is only consumed by the register file; rs_data arrives already read
    assign w_unused_rs_field = ^instr[25:21];

    assign w_op   = instr[31:26];
    assign w_fn   = instr[5:0];
    assign w_sext = {{16{instr[15]}}, instr[15:0]};
    assign w_zext = {16'b0, instr[15:0]};

    // Instruction decode; illegal words fall through with all fields zero
    always_comb begin
        w_legal = 1'b0;
        w_aluop = ALU_ADD;
        w_a     = '0;
        w_b     = '0;
        w_dst   = '0;
        case (w_op)
            6'h00: begin
                w_legal = 1'b1;
                w_a     = rs_data;
                w_b     = rt_data;
                w_dst   = instr[15:11];
                case (w_fn)
                    6'h20, 6'h21: w_aluop = ALU_ADD;
                    6'h22, 6'h23: w_aluop = ALU_SUB;
                    6'h24:        w_aluop = ALU_AND;
                    6'h25:        w_aluop = ALU_OR;
                    6'h26:        w_aluop = ALU_XOR;
                    6'h27:        w_aluop = ALU_NOR;
                    6'h2A:        w_aluop = ALU_SLT;
                    6'h2B:        w_aluop = ALU_SLTU;
                    6'h00, 6'h02, 6'h03: begin
                        w_aluop = (w_fn == 6'h00) ? ALU_SLL :
                                  (w_fn == 6'h02) ? ALU_SRL : ALU_SRA;
                        w_a     = rt_data;
                        w_b     = {27'b0, instr[10:6]};
                    end
                    default: begin
                        w_legal = 1'b0;
                        w_a     = '0;
                        w_b     = '0;
                        w_dst   = '0;
                    end
                endcase
            end
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E: begin
                w_legal = 1'b1;
                w_a     = rs_data;
                w_dst   = instr[20:16];
                case (w_op)
                    6'h0A:   begin w_aluop = ALU_SLT;  w_b = w_sext; end
                    6'h0B:   begin w_aluop = ALU_SLTU; w_b = w_sext; end
                    6'h0C:   begin w_aluop = ALU_AND;  w_b = w_zext; end
                    6'h0D:   begin w_aluop = ALU_OR;   w_b = w_zext; end
                    6'h0E:   begin w_aluop = ALU_XOR;  w_b = w_zext; end
                    default: begin w_aluop = ALU_ADD;  w_b = w_sext; end
                endcase
            end
            6'h0F: begin
                w_legal = 1'b1;
                w_aluop = ALU_OR;
                w_a     = {instr[15:0], 16'b0};
                w_b     = '0;
                w_dst   = instr[20:16];
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase
    end

    // Writes to $0 are architecturally discarded, so suppress write-back
    assign w_regwrite = w_legal && (w_dst != '0);

    assign in_ready = !stall;

    // Pipeline register: flush beats stall beats load/bubble
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid    <= 1'b0;
            r_aluop    <= ALU_ADD;
            r_a        <= '0;
            r_b        <= '0;
            r_regwrite <= 1'b0;
            r_dst      <= '0;
            r_illegal  <= 1'b0;
            r_cnt      <= '0;
        end else if (flush) begin
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
            r_illegal  <= 1'b0;
            r_aluop    <= ALU_ADD;
        end else if (!stall) begin
            if (in_valid) begin
                r_valid    <= 1'b1;
                r_aluop    <= w_aluop;
                r_a        <= w_a;
                r_b        <= w_b;
                r_regwrite <= w_regwrite;
                r_dst      <= w_dst;
                r_illegal  <= !w_legal;
                if (!w_legal && (r_cnt != CNT_MAX)) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else begin
                r_valid    <= 1'b0;
                r_regwrite <= 1'b0;
                r_illegal  <= 1'b0;
            end
        end
    end

    assign ex_valid    = r_valid;
    assign ex_aluop    = r_aluop;
    assign ex_a        = r_a;
    assign ex_b        = r_b;
    assign ex_regwrite = r_regwrite;
    assign ex_dst      = r_dst;
    assign ex_illegal  = r_illegal;
    assign illegal_cnt = r_cnt;

endmodule
